// File: rtl/param_cache_controller_if.sv
// rtl/param_cache_controller_if.sv - CPU-side and memory-side bus bundle for the cache controller
interface param_cache_controller_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 16
);
   logic              cpu_req;
   logic              cpu_write;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              flush;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready;
   logic              cache_miss;
   logic [ADDR_W-1:0] miss_address;
   logic              mem_req;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic [CNT_W-1:0]  hit_count;
   logic [CNT_W-1:0]  miss_count;

   // Controller side
   modport slave (
      input  cpu_req, cpu_write, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
      output cpu_rdata, cpu_ready, cache_miss, miss_address,
             mem_req, mem_write, mem_addr, mem_wdata, hit_count, miss_count
   );

   // CPU pipeline / memory arbiter side
   modport master (
      output cpu_req, cpu_write, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
      input  cpu_rdata, cpu_ready, cache_miss, miss_address,
             mem_req, mem_write, mem_addr, mem_wdata, hit_count, miss_count
   );
endinterface

// File: rtl/param_cache_controller.sv
// rtl/param_cache_controller.sv - direct-mapped write-through cache with miss-fill FSM
module param_cache_controller #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int NUM_LINES  = 8,
   parameter int LINE_WORDS = 4,
   parameter int CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   param_cache_controller_if.slave  bus
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

   state_t            state;
   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]  tag_mem  [0:NUM_LINES-1];
   logic [DATA_W-1:0] data_mem [0:NUM_LINES*LINE_WORDS-1];

   logic [OFF_W-1:0]  word_cnt;
   logic [ADDR_W-1:0] miss_address;
   logic              mem_req;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [CNT_W-1:0]  hit_count;
   logic [CNT_W-1:0]  miss_count;
   logic              cpu_ready;

   // Address fields of the live CPU request
   logic [OFF_W-1:0]  cpu_off;
   logic [IDX_W-1:0]  cpu_idx;
   logic [TAG_W-1:0]  cpu_tag;
   logic              cpu_hit;
   assign cpu_off = bus.cpu_addr[OFF_W-1:0];
   assign cpu_idx = bus.cpu_addr[OFF_W +: IDX_W];
   assign cpu_tag = bus.cpu_addr[ADDR_W-1 -: TAG_W];
   assign cpu_hit = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);

   // The fill targets the latched miss line, never the live CPU address
   logic [IDX_W-1:0]  miss_idx;
   logic [TAG_W-1:0]  miss_tag;
   logic [OFF_W-1:0]  next_cnt;
   assign miss_idx = miss_address[OFF_W +: IDX_W];
   assign miss_tag = miss_address[ADDR_W-1 -: TAG_W];
   assign next_cnt = word_cnt + 1'b1;

   // Write-through updates use the latched write address
   logic [OFF_W-1:0]  wr_off;
   logic [IDX_W-1:0]  wr_idx;
   logic [TAG_W-1:0]  wr_tag;
   logic              wr_hit;
   assign wr_off = mem_addr[OFF_W-1:0];
   assign wr_idx = mem_addr[OFF_W +: IDX_W];
   assign wr_tag = mem_addr[ADDR_W-1 -: TAG_W];
   assign wr_hit = valid[wr_idx] && (tag_mem[wr_idx] == wr_tag);

   // CPU completion: same-cycle read hits, or the memory ack of a write
   always_comb begin
      cpu_ready = 1'b0;
      case (state)
         IDLE:    cpu_ready = bus.cpu_req && !bus.cpu_write && !bus.flush && cpu_hit;
         WRITE:   cpu_ready = bus.mem_ack;
         default: cpu_ready = 1'b0;
      endcase
   end

   // Controller FSM with registered memory-side outputs and saturating counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         valid        <= '0;
         word_cnt     <= '0;
         miss_address <= '0;
         mem_req      <= 1'b0;
         mem_write    <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         hit_count    <= '0;
         miss_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.flush) begin
                  valid <= '0;
               end else if (bus.cpu_req) begin
                  if (bus.cpu_write) begin
                     state     <= WRITE;
                     mem_req   <= 1'b1;
                     mem_write <= 1'b1;
                     mem_addr  <= bus.cpu_addr;
                     mem_wdata <= bus.cpu_wdata;
                  end else if (cpu_hit) begin
                     if (hit_count != {CNT_W{1'b1}})
                        hit_count <= hit_count + CNT_W'(1);
                  end else begin
                     state        <= FILL;
                     miss_address <= {bus.cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                     mem_addr     <= {bus.cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                     word_cnt     <= '0;
                     mem_req      <= 1'b1;
                     mem_write    <= 1'b0;
                     if (miss_count != {CNT_W{1'b1}})
                        miss_count <= miss_count + CNT_W'(1);
                  end
               end
            end
            FILL: begin
               if (bus.mem_ack) begin
                  word_cnt <= next_cnt;
                  if (word_cnt == LAST_WORD) begin
                     valid[miss_idx] <= 1'b1;
                     mem_req         <= 1'b0;
                     state           <= IDLE;
                  end else begin
                     mem_addr <= miss_address + ADDR_W'(next_cnt);
                  end
               end
            end
            WRITE: begin
               if (bus.mem_ack) begin
                  mem_req   <= 1'b0;
                  mem_write <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Line storage: fill words and tag on the last ack, write-through updates of resident words
   always_ff @(posedge clk) begin
      if (!rst && state == FILL && bus.mem_ack) begin
         data_mem[{miss_idx, word_cnt}] <= bus.mem_rdata;
         if (word_cnt == LAST_WORD)
            tag_mem[miss_idx] <= miss_tag;
      end else if (!rst && state == WRITE && bus.mem_ack && wr_hit) begin
         data_mem[{wr_idx, wr_off}] <= mem_wdata;
      end
   end

   assign bus.cpu_rdata    = data_mem[{cpu_idx, cpu_off}];
   assign bus.cpu_ready    = cpu_ready;
   assign bus.cache_miss   = (state == FILL);
   assign bus.miss_address = miss_address;
   assign bus.mem_req      = mem_req;
   assign bus.mem_write    = mem_write;
   assign bus.mem_addr     = mem_addr;
   assign bus.mem_wdata    = mem_wdata;
   assign bus.hit_count    = hit_count;
   assign bus.miss_count   = miss_count;
endmodule

// File: tb/tb_param_cache_controller.sv
// tb/tb_param_cache_controller.sv - directed self-checking bench for param_cache_controller
module tb_param_cache_controller;
   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   param_cache_controller_if #(.DATA_W(16), .ADDR_W(16), .CNT_W(16)) bus ();

   param_cache_controller #(
      .DATA_W(16), .ADDR_W(16), .NUM_LINES(8), .LINE_WORDS(4), .CNT_W(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: rdata = addr ^ 16'hA5A5, ack in the second cycle of each request
   logic        mem_manual = 1'b0;
   logic        auto_ack   = 1'b0;
   logic [15:0] auto_rdata = '0;
   logic        man_ack    = 1'b0;
   logic [15:0] man_rdata  = '0;
   int          ack_cnt    = 0;
   assign bus.mem_ack   = mem_manual ? man_ack : auto_ack;
   assign bus.mem_rdata = mem_manual ? man_rdata : auto_rdata;

   always @(posedge clk) begin
      #1;
      if (mem_manual) begin
         auto_ack = 1'b0;
         ack_cnt  = 0;
      end else if (auto_ack) begin
         auto_ack = 1'b0;
         ack_cnt  = bus.mem_req ? 1 : 0;
      end else if (bus.mem_req) begin
         ack_cnt++;
         if (ack_cnt == 2) begin
            auto_ack   = 1'b1;
            auto_rdata = bus.mem_addr ^ 16'hA5A5;
            ack_cnt    = 0;
         end
      end else begin
         ack_cnt = 0;
      end
   end

   // Transaction log filled by the access driver
   logic [15:0] log_addr [8];
   logic        log_wr   [8];
   logic [15:0] log_data [8];
   int          log_n;

   int          cyc;
   logic [15:0] rd;
   logic        saw_miss;
   logic        saw_req;

   // Drive one CPU access until cpu_ready (cycle 1 = request cycle); optional flush on cycle 1
   task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d, input logic fl);
      logic done;
      done     = 1'b0;
      cyc      = 0;
      rd       = 'x;
      saw_miss = 1'b0;
      saw_req  = 1'b0;
      log_n    = 0;
      @(negedge clk);
      bus.cpu_req   = 1'b1;
      bus.cpu_write = w;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      bus.flush     = fl;
      while (!done) begin
         #1;
         cyc++;
         if (bus.cache_miss) saw_miss = 1'b1;
         if (bus.mem_req) saw_req = 1'b1;
         if (bus.mem_req && bus.mem_ack && log_n < 8) begin
            log_addr[log_n] = bus.mem_addr;
            log_wr[log_n]   = bus.mem_write;
            log_data[log_n] = bus.mem_write ? bus.mem_wdata : bus.mem_rdata;
            log_n++;
         end
         if (bus.cpu_ready) begin
            rd   = bus.cpu_rdata;
            done = 1'b1;
         end else if (cyc >= 60) begin
            done = 1'b1;
         end else begin
            @(negedge clk);
            bus.flush = 1'b0;
         end
      end
      @(negedge clk);
      bus.cpu_req   = 1'b0;
      bus.cpu_write = 1'b0;
      bus.flush     = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      total++; if (bus.cpu_ready !== 1'b0) begin bad++; $display("FAIL reset_cpu_ready: got %b expected 0", bus.cpu_ready); end
      total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
      total++; if (bus.mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write: got %b expected 0", bus.mem_write); end
      total++; if (bus.mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_mem_addr: got %h expected 0000", bus.mem_addr); end
      total++; if (bus.mem_wdata !== 16'h0000) begin bad++; $display("FAIL reset_mem_wdata: got %h expected 0000", bus.mem_wdata); end
      total++; if (bus.miss_address !== 16'h0000) begin bad++; $display("FAIL reset_miss_address: got %h expected 0000", bus.miss_address); end
      total++; if (bus.cache_miss !== 1'b0) begin bad++; $display("FAIL reset_cache_miss: got %b expected 0", bus.cache_miss); end
      total++; if (bus.hit_count !== 16'd0) begin bad++; $display("FAIL reset_hit_count: got %0d expected 0", bus.hit_count); end
      total++; if (bus.miss_count !== 16'd0) begin bad++; $display("FAIL reset_miss_count: got %0d expected 0", bus.miss_count); end
   endtask

   task automatic test_read_miss();
      logic [15:0] exp_addr;
      access(1'b0, 16'h0010, 16'h0000, 1'b0);
      total++; if (cyc !== 10) begin bad++; $display("FAIL miss_latency: got %0d expected 10", cyc); end
      total++; if (rd !== 16'hA5B5) begin bad++; $display("FAIL miss_rdata: got %h expected a5b5", rd); end
      total++; if (saw_miss !== 1'b1) begin bad++; $display("FAIL miss_cache_miss: got %b expected 1", saw_miss); end
      total++; if (log_n !== 4) begin bad++; $display("FAIL miss_mem_count: got %0d expected 4", log_n); end
      for (int i = 0; i < 4; i++) begin
         exp_addr = 16'h0010 + 16'(i);
         total++;
         if (log_addr[i] !== exp_addr || log_wr[i] !== 1'b0) begin
            bad++; $display("FAIL miss_mem_read%0d: got addr %h wr %b expected addr %h wr 0", i, log_addr[i], log_wr[i], exp_addr);
         end
      end
      total++; if (bus.miss_count !== 16'd1) begin bad++; $display("FAIL miss_miss_count: got %0d expected 1", bus.miss_count); end
      total++; if (bus.hit_count !== 16'd1) begin bad++; $display("FAIL miss_hit_count: got %0d expected 1", bus.hit_count); end
      total++; if (bus.miss_address !== 16'h0010) begin bad++; $display("FAIL miss_address: got %h expected 0010", bus.miss_address); end
      total++; if (bus.cache_miss !== 1'b0) begin bad++; $display("FAIL miss_done_cache_miss: got %b expected 0", bus.cache_miss); end
   endtask

   task automatic test_read_hit();
      access(1'b0, 16'h0012, 16'h0000, 1'b0);
      total++; if (cyc !== 1) begin bad++; $display("FAIL hit_latency: got %0d expected 1", cyc); end
      total++; if (rd !== 16'hA5B7) begin bad++; $display("FAIL hit_rdata: got %h expected a5b7", rd); end
      total++; if (saw_req !== 1'b0) begin bad++; $display("FAIL hit_mem_req: got %b expected 0", saw_req); end
      total++; if (bus.hit_count !== 16'd2) begin bad++; $display("FAIL hit_hit_count: got %0d expected 2", bus.hit_count); end
   endtask

   task automatic test_evict();
      access(1'b0, 16'h0030, 16'h0000, 1'b0);
      total++; if (cyc !== 10) begin bad++; $display("FAIL evict_latency: got %0d expected 10", cyc); end
      total++; if (rd !== 16'hA595) begin bad++; $display("FAIL evict_rdata: got %h expected a595", rd); end
      total++; if (log_addr[0] !== 16'h0030 || log_addr[3] !== 16'h0033) begin
         bad++; $display("FAIL evict_fill_addr: got %h..%h expected 0030..0033", log_addr[0], log_addr[3]);
      end
      access(1'b0, 16'h0010, 16'h0000, 1'b0);
      total++; if (cyc !== 10) begin bad++; $display("FAIL evict_refill_latency: got %0d expected 10", cyc); end
      total++; if (bus.miss_count !== 16'd3) begin bad++; $display("FAIL evict_miss_count: got %0d expected 3", bus.miss_count); end
      total++; if (bus.hit_count !== 16'd4) begin bad++; $display("FAIL evict_hit_count: got %0d expected 4", bus.hit_count); end
   endtask

   task automatic test_write();
      access(1'b1, 16'h0011, 16'h1234, 1'b0);
      total++; if (cyc !== 3) begin bad++; $display("FAIL wr_hit_latency: got %0d expected 3", cyc); end
      total++; if (log_n !== 1 || log_wr[0] !== 1'b1 || log_addr[0] !== 16'h0011 || log_data[0] !== 16'h1234) begin
         bad++; $display("FAIL wr_hit_mem: got n %0d wr %b addr %h data %h expected n 1 wr 1 addr 0011 data 1234",
                         log_n, log_wr[0], log_addr[0], log_data[0]);
      end
      access(1'b0, 16'h0011, 16'h0000, 1'b0);
      total++; if (cyc !== 1 || rd !== 16'h1234) begin
         bad++; $display("FAIL wr_hit_readback: got cyc %0d data %h expected cyc 1 data 1234", cyc, rd);
      end
      access(1'b1, 16'h0050, 16'hBEEF, 1'b0);
      total++; if (cyc !== 3 || log_addr[0] !== 16'h0050 || log_data[0] !== 16'hBEEF) begin
         bad++; $display("FAIL wr_miss_mem: got cyc %0d addr %h data %h expected cyc 3 addr 0050 data beef", cyc, log_addr[0], log_data[0]);
      end
      access(1'b0, 16'h0050, 16'h0000, 1'b0);
      total++; if (cyc !== 10 || rd !== 16'hA5F5) begin
         bad++; $display("FAIL wr_miss_noalloc: got cyc %0d data %h expected cyc 10 data a5f5", cyc, rd);
      end
      total++; if (bus.miss_count !== 16'd4) begin bad++; $display("FAIL wr_miss_count: got %0d expected 4", bus.miss_count); end
      total++; if (bus.hit_count !== 16'd6) begin bad++; $display("FAIL wr_hit_count: got %0d expected 6", bus.hit_count); end
   endtask

   task automatic test_flush();
      access(1'b0, 16'h0050, 16'h0000, 1'b1);
      total++; if (cyc !== 11) begin bad++; $display("FAIL flush_latency: got %0d expected 11", cyc); end
      total++; if (rd !== 16'hA5F5) begin bad++; $display("FAIL flush_rdata: got %h expected a5f5", rd); end
      total++; if (saw_miss !== 1'b1) begin bad++; $display("FAIL flush_refill: got %b expected 1", saw_miss); end
      total++; if (bus.miss_count !== 16'd5) begin bad++; $display("FAIL flush_miss_count: got %0d expected 5", bus.miss_count); end
      total++; if (bus.hit_count !== 16'd7) begin bad++; $display("FAIL flush_hit_count: got %0d expected 7", bus.hit_count); end
   endtask

   task automatic test_reset_mid_fill();
      int acks = 0;
      int n    = 0;
      @(negedge clk);
      bus.cpu_req   = 1'b1;
      bus.cpu_write = 1'b0;
      bus.cpu_addr  = 16'h0010;
      while (acks < 2 && n < 60) begin
         #1;
         n++;
         if (bus.mem_req && bus.mem_ack) acks++;
         if (acks < 2) @(negedge clk);
      end
      total++; if (acks !== 2) begin bad++; $display("FAIL rst_fill_acks: got %0d expected 2", acks); end
      @(negedge clk);
      rst         = 1'b1;
      bus.cpu_req = 1'b0;
      mem_manual  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (bus.mem_req !== 1'b0 || bus.cache_miss !== 1'b0) begin
         bad++; $display("FAIL rst_abort: got mem_req %b cache_miss %b expected 0 0", bus.mem_req, bus.cache_miss);
      end
      total++; if (bus.miss_count !== 16'd0 || bus.hit_count !== 16'd0) begin
         bad++; $display("FAIL rst_counters: got miss %0d hit %0d expected 0 0", bus.miss_count, bus.hit_count);
      end
      man_ack   = 1'b1;
      man_rdata = 16'hDEAD;
      @(negedge clk);
      #1;
      total++; if (bus.mem_req !== 1'b0 || bus.cache_miss !== 1'b0 || bus.cpu_ready !== 1'b0) begin
         bad++; $display("FAIL rst_late_ack: got mem_req %b cache_miss %b ready %b expected 0 0 0",
                         bus.mem_req, bus.cache_miss, bus.cpu_ready);
      end
      man_ack    = 1'b0;
      mem_manual = 1'b0;
      access(1'b0, 16'h0010, 16'h0000, 1'b0);
      total++; if (cyc !== 10 || log_n !== 4) begin
         bad++; $display("FAIL rst_refill: got cyc %0d reads %0d expected cyc 10 reads 4", cyc, log_n);
      end
      total++; if (rd !== 16'hA5B5) begin bad++; $display("FAIL rst_refill_rdata: got %h expected a5b5", rd); end
      total++; if (bus.miss_count !== 16'd1 || bus.hit_count !== 16'd1) begin
         bad++; $display("FAIL rst_refill_counts: got miss %0d hit %0d expected 1 1", bus.miss_count, bus.hit_count);
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.cpu_req   = 1'b0;
      bus.cpu_write = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.flush     = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_read_miss();
      test_read_hit();
      test_evict();
      test_write();
      test_flush();
      test_reset_mid_fill();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
